// File: rtl/mo_bfly_post_pkg.sv
// mo_bfly_post_pkg: shared NTT constants, coefficient/product types and modular normalisation
package mo_bfly_post_pkg;
  localparam int WIDTH = 12;
  localparam int Q = 3329;
  localparam int MUL_LAT = WIDTH;
  localparam int FIFO_DEPTH = 4;
  typedef logic [WIDTH-1:0] coeff_t;
  typedef logic signed [WIDTH:0] prod_t;
  localparam coeff_t QA = coeff_t'(Q);
  localparam prod_t QP = prod_t'(Q);
  localparam logic signed [WIDTH+1:0] QX = (WIDTH+2)'(Q);
  // folds x in -Q..2Q-1 into 0..Q-1 with a single conditional add or subtract
  function automatic coeff_t mod_norm(input logic signed [WIDTH+1:0] x);
    return x[WIDTH+1] ? coeff_t'(x + QX) : x >= QX ? coeff_t'(x - QX) : coeff_t'(x);
  endfunction
endpackage

// File: rtl/mo_bfly_post_if.sv
// mo_bfly_post_if: launch and result handshakes around the butterfly post-processor
interface mo_bfly_post_if;
  import mo_bfly_post_pkg::*;
  logic in_valid;
  logic in_ready;
  coeff_t in_a;
  prod_t prod_in;
  logic out_valid;
  logic out_ready;
  coeff_t out_sum;
  coeff_t out_diff;
  modport slave (input in_valid, in_a, prod_in, out_ready, output in_ready, out_valid, out_sum, out_diff);
  modport master (output in_valid, in_a, prod_in, out_ready, input in_ready, out_valid, out_sum, out_diff);
endinterface

// File: rtl/mo_bfly_post_bfly_fifo.sv
// bfly_fifo: first-word fall-through FIFO, power-of-two depth, accepts write while full if popping
module bfly_fifo #(
  parameter int DW = 24,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_i,
  input  logic [DW-1:0]             din_i,
  input  logic                      rd_i,
  output logic [DW-1:0]             dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_rd, do_wr;
  assign do_rd = rd_i && !empty_o;
  assign do_wr = wr_i && (!full_o || do_rd);
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rp_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) mem_q[wp_q] <= din_i;
      wp_q <= wp_q + AW'(do_wr);
      rp_q <= rp_q + AW'(do_rd);
      cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/mo_bfly_post.sv
// mo_bfly_post: aligns a with the multiplier product, forms (a+p, a-p) mod Q, buffers under credit flow control
module mo_bfly_post
  import mo_bfly_post_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  mo_bfly_post_if.slave io
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic dl_v_q [MUL_LAT];
  coeff_t dl_a_q [MUL_LAT];
  logic [CW-1:0] credit_q, credit_d;
  logic accept, pop, fifo_full, fifo_empty;
  logic [AW:0] fifo_cnt;
  logic [2*WIDTH-1:0] fifo_dout;
  logic signed [WIDTH+1:0] a_x, p_x;
  coeff_t sum_n, diff_n;
  assign accept = io.in_valid && io.in_ready;
  assign pop = io.out_valid && io.out_ready;
  // credit is registered so in_ready never depends combinationally on out_ready
  assign io.in_ready = credit_q < CW'(FIFO_DEPTH);
  assign io.out_valid = !fifo_empty;
  assign io.out_sum = fifo_dout[2*WIDTH-1:WIDTH];
  assign io.out_diff = fifo_dout[WIDTH-1:0];
  always_comb begin
    a_x = {2'b00, dl_a_q[MUL_LAT-1]};
    p_x = {io.prod_in[WIDTH], io.prod_in};
    sum_n = mod_norm(a_x + p_x);
    diff_n = mod_norm(a_x - p_x);
    credit_d = credit_q + CW'(accept) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        dl_v_q[i] <= 1'b0;
        dl_a_q[i] <= '0;
      end
      credit_q <= '0;
    end else begin
      dl_v_q[0] <= accept;
      dl_a_q[0] <= io.in_a;
      for (int i = 1; i < MUL_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_a_q[i] <= dl_a_q[i-1];
      end
      credit_q <= credit_d;
    end
  bfly_fifo #(.DW(2*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_i(dl_v_q[MUL_LAT-1]), .din_i({sum_n, diff_n}), .rd_i(pop),
    .dout_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty), .count_o(fifo_cnt)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(dl_v_q[MUL_LAT-1] && fifo_full && !pop));
  a_credit_covers: assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= credit_q);
  a_a_range: assert property (@(posedge clk) disable iff (!rst_n) accept |-> io.in_a < QA);
  a_p_range: assert property (@(posedge clk) disable iff (!rst_n) dl_v_q[MUL_LAT-1] |-> (io.prod_in <= QP && io.prod_in >= -QP));
endmodule

// File: tb/tb_mo_bfly_post.sv
// tb_mo_bfly_post: randomized and directed checks against a queue-based butterfly model
module tb_mo_bfly_post;
  import mo_bfly_post_pkg::*;
  typedef struct {int s; int d; int avail;} item_t;
  logic clk = 1'b0;
  logic rst_n;
  mo_bfly_post_if io();
  mo_bfly_post dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  item_t q[$];
  int sp[32];
  bit sv[32];
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int md(input int x);
    return ((x % Q) + Q) % Q;
  endfunction
  function automatic int rnd_p();
    return int'($urandom_range(2 * Q)) - Q;
  endfunction
  function automatic int rnd_a();
    return int'($urandom_range(Q - 1));
  endfunction
  task automatic step(input bit v, input int a, input int p, input bit rdy);
    bit ev;
    io.in_valid = v;
    io.in_a = coeff_t'(a);
    io.out_ready = rdy;
    ev = q.size() > 0 && q[0].avail <= cyc;
    chk("in_ready", int'(io.in_ready), int'(q.size() < FIFO_DEPTH));
    chk("out_valid", int'(io.out_valid), int'(ev));
    if (ev) begin
      chk("out_sum", int'(io.out_sum), q[0].s);
      chk("out_diff", int'(io.out_diff), q[0].d);
      if (rdy) void'(q.pop_front());
    end
    if (v && io.in_ready) begin
      q.push_back(item_t'{md(a + p), md(a - p), cyc + 13});
      sp[(cyc + 12) % 32] = p;
      sv[(cyc + 12) % 32] = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    io.prod_in = prod_t'(sv[cyc % 32] ? sp[cyc % 32] : rnd_p());
    sv[cyc % 32] = 1'b0;
  endtask
  task automatic dir(input int a, input int p, input int es, input int ed);
    int n;
    n = 1;
    step(1'b1, a, p, 1'b0);
    while (!io.out_valid && n < 30) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    chk("latency", n, 13);
    chk("dir_sum", int'(io.out_sum), es);
    chk("dir_diff", int'(io.out_diff), ed);
    step(1'b0, 0, 0, 1'b1);
  endtask
  task automatic drain();
    for (int i = 0; i < 30; i++) step(1'b0, 0, 0, 1'b1);
  endtask
  initial begin
    int acc;
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    io.in_a = '0;
    io.prod_in = '0;
    io.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_out_sum", int'(io.out_sum), 0);
    chk("rst_out_diff", int'(io.out_diff), 0);
    chk("rst_in_ready", int'(io.in_ready), 1);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    dir(100, 200, 300, 3229);
    dir(3328, 3329, 3328, 3328);
    dir(0, -3329, 0, 0);
    dir(3000, 1000, 671, 2000);
    dir(5, -3000, 334, 3005);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (io.in_ready) acc++;
      step(1'b1, rnd_a(), rnd_p(), 1'b0);
    end
    chk("bp_accepts", acc, 4);
    step(1'b0, 0, 0, 1'b1);
    chk("bp_ready_after_pop", int'(io.in_ready), 1);
    step(1'b1, rnd_a(), rnd_p(), 1'b0);
    drain();
    for (int i = 0; i < 50; i++) step(1'b1, rnd_a(), rnd_p(), 1'b1);
    drain();
    for (int i = 0; i < 300; i++)
      step($urandom_range(9) < 7, rnd_a(), rnd_p(), $urandom_range(9) < 6);
    drain();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_a(), rnd_p(), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(io.out_valid), 0);
    chk("mid_rst_out_sum", int'(io.out_sum), 0);
    chk("mid_rst_out_diff", int'(io.out_diff), 0);
    chk("mid_rst_in_ready", int'(io.in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 0; i < 32; i++) sv[i] = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 1'b1);
    dir(1, 2, 3, 3328);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
